// File: rtl/apb_cmd_master.sv
// APB requester: turns a valid/ready read/write command into one APB transfer and
// returns the result on a valid/ready response channel. Define APB_TIMEOUT_EN to abort stuck transfers.
module apb_cmd_master #(
   parameter logic [31:0] BASE_ADDR    = 32'h7000_0000,
   parameter int unsigned WINDOW_BYTES = 16,
   parameter int unsigned TIMEOUT_CYC  = 16
) (
   input  logic        pclk,
   input  logic        preset,
   input  logic        cmd_valid,
   output logic        cmd_ready,
   input  logic        cmd_write,
   input  logic [31:0] cmd_addr,
   input  logic [31:0] cmd_wdata,
   output logic        rsp_valid,
   input  logic        rsp_ready,
   output logic [31:0] rsp_rdata,
   output logic        rsp_err,
   output logic        psel,
   output logic        penable,
   output logic        pwrite,
   output logic [31:0] paddr,
   output logic [31:0] pwdata,
   input  logic [31:0] prdata,
   input  logic        pready,
   input  logic        pslverr
);

   typedef enum logic [1:0] {StIdle, StSetup, StAccess, StResp} state_e;

   state_e state_q;

   // Subtracting the base first lets addresses below the window wrap to large offsets.
   logic [31:0] cmd_off;
   logic        cmd_ok;

   assign cmd_off = cmd_addr - BASE_ADDR;
   assign cmd_ok  = (cmd_off < WINDOW_BYTES) && (cmd_addr[1:0] == 2'b00);

   if ((WINDOW_BYTES < 4) || ((WINDOW_BYTES & (WINDOW_BYTES - 1)) != 0)) begin : g_bad_window
      $error("WINDOW_BYTES must be a power of two and at least 4");
   end
   if (TIMEOUT_CYC < 1) begin : g_bad_timeout
      $error("TIMEOUT_CYC must be at least 1");
   end

`ifdef APB_TIMEOUT_EN
   localparam int unsigned TmoW = $clog2(TIMEOUT_CYC + 1);
   logic [TmoW-1:0] tmo_cnt_q;
`endif

   always_ff @(posedge pclk) begin
      if (preset) begin
         state_q   <= StIdle;
         cmd_ready <= 1'b0;
         rsp_valid <= 1'b0;
         rsp_rdata <= '0;
         rsp_err   <= 1'b0;
         psel      <= 1'b0;
         penable   <= 1'b0;
         pwrite    <= 1'b0;
         paddr     <= '0;
         pwdata    <= '0;
`ifdef APB_TIMEOUT_EN
         tmo_cnt_q <= '0;
`endif
      end else begin
         unique case (state_q)
            StIdle: begin
               if (cmd_valid && cmd_ready) begin
                  cmd_ready <= 1'b0;
                  if (cmd_ok) begin
                     state_q <= StSetup;
                     psel    <= 1'b1;
                     pwrite  <= cmd_write;
                     paddr   <= cmd_addr;
                     pwdata  <= cmd_wdata;
                  end else begin
                     // Rejected locally; the bus is never touched.
                     state_q   <= StResp;
                     rsp_valid <= 1'b1;
                     rsp_err   <= 1'b1;
                     rsp_rdata <= '0;
                  end
               end else begin
                  cmd_ready <= 1'b1;
               end
            end

            StSetup: begin
               penable <= 1'b1;
               state_q <= StAccess;
`ifdef APB_TIMEOUT_EN
               tmo_cnt_q <= '0;
`endif
            end

            StAccess: begin
               if (pready) begin
                  state_q   <= StResp;
                  rsp_valid <= 1'b1;
                  rsp_err   <= pslverr;
                  rsp_rdata <= pwrite ? 32'h0 : prdata;
                  psel      <= 1'b0;
                  penable   <= 1'b0;
                  pwrite    <= 1'b0;
                  paddr     <= '0;
                  pwdata    <= '0;
               end
`ifdef APB_TIMEOUT_EN
               else if (tmo_cnt_q == TmoW'(TIMEOUT_CYC - 1)) begin
                  state_q   <= StResp;
                  rsp_valid <= 1'b1;
                  rsp_err   <= 1'b1;
                  rsp_rdata <= '0;
                  psel      <= 1'b0;
                  penable   <= 1'b0;
                  pwrite    <= 1'b0;
                  paddr     <= '0;
                  pwdata    <= '0;
               end else begin
                  tmo_cnt_q <= tmo_cnt_q + 1'b1;
               end
`endif
            end

            StResp: begin
               if (rsp_ready) begin
                  state_q   <= StIdle;
                  rsp_valid <= 1'b0;
                  rsp_err   <= 1'b0;
                  rsp_rdata <= '0;
                  cmd_ready <= 1'b1;
               end
            end

            default: state_q <= StIdle;
         endcase
      end
   end

endmodule

// File: tb/tb_apb_cmd_master.sv
// Directed bench for apb_cmd_master with a small 4-word APB slave model.
module tb_apb_cmd_master;

   logic        pclk = 1'b0;
   logic        preset = 1'b1;
   logic        cmd_valid = 1'b0;
   logic        cmd_ready;
   logic        cmd_write = 1'b0;
   logic [31:0] cmd_addr = '0;
   logic [31:0] cmd_wdata = '0;
   logic        rsp_valid;
   logic        rsp_ready = 1'b0;
   logic [31:0] rsp_rdata;
   logic        rsp_err;
   logic        psel, penable, pwrite;
   logic [31:0] paddr, pwdata, prdata;
   logic        pready, pslverr;

   apb_cmd_master #(
      .BASE_ADDR   (32'h7000_0000),
      .WINDOW_BYTES(16),
      .TIMEOUT_CYC (16)
   ) dut (
      .pclk     (pclk),
      .preset   (preset),
      .cmd_valid(cmd_valid),
      .cmd_ready(cmd_ready),
      .cmd_write(cmd_write),
      .cmd_addr (cmd_addr),
      .cmd_wdata(cmd_wdata),
      .rsp_valid(rsp_valid),
      .rsp_ready(rsp_ready),
      .rsp_rdata(rsp_rdata),
      .rsp_err  (rsp_err),
      .psel     (psel),
      .penable  (penable),
      .pwrite   (pwrite),
      .paddr    (paddr),
      .pwdata   (pwdata),
      .prdata   (prdata),
      .pready   (pready),
      .pslverr  (pslverr)
   );

   always #5 pclk = ~pclk;

   // Slave model: n_wait wait states per access, hang holds pready low.
   logic [31:0] mem [4] = '{32'h0, 32'h0b1407e9, 32'h0, 32'h4b455931};
   int          acc_cnt = 0;
   int          n_wait = 0;
   bit          hang = 1'b0;
   bit          slv_err = 1'b0;

   assign pready  = !hang && psel && penable && (acc_cnt == n_wait);
   assign pslverr = slv_err && pready;
   assign prdata  = mem[paddr[3:2]];

   always @(posedge pclk) begin
      acc_cnt <= (psel && penable && !pready) ? acc_cnt + 1 : 0;
      if (psel && penable && pready && pwrite && !pslverr) mem[paddr[3:2]] <= pwdata;
   end

   int          nvec = 0;
   int          nfail = 0;
   int          lat, pen_cyc;
   bit          psel_seen, addr_ok;
   logic [31:0] r_data;
   logic        r_err;

   task automatic tick;
      @(posedge pclk);
      #1;
   endtask

   // Issue one command and follow it until rsp_valid (not consumed).
   task automatic do_cmd(input logic wr, input logic [31:0] a, input logic [31:0] d);
      int w = 0;
      while (!cmd_ready && w < 20) begin
         tick();
         w++;
      end
      cmd_valid = 1'b1;
      cmd_write = wr;
      cmd_addr  = a;
      cmd_wdata = d;
      tick();
      cmd_valid = 1'b0;
      lat = 1;
      pen_cyc = 0;
      psel_seen = 1'b0;
      addr_ok = 1'b1;
      while (!rsp_valid && lat < 200) begin
         if (psel) begin
            psel_seen = 1'b1;
            if (paddr !== a || pwrite !== wr || (wr && pwdata !== d)) addr_ok = 1'b0;
         end
         if (penable) pen_cyc++;
         tick();
         lat++;
      end
      r_data = rsp_rdata;
      r_err  = rsp_err;
   endtask

   task automatic rsp_take;
      rsp_ready = 1'b1;
      tick();
      rsp_ready = 1'b0;
   endtask

   task automatic test_reset;
      preset = 1'b1;
      tick();
      tick();
      nvec++;
      if (cmd_ready !== 1'b0) begin
         nfail++;
         $display("FAIL reset_cmd_ready: got %b want 0", cmd_ready);
      end
      nvec++;
      if ({psel, penable, pwrite, rsp_valid, rsp_err} !== 5'b0 ||
          paddr !== 32'h0 || pwdata !== 32'h0 || rsp_rdata !== 32'h0) begin
         nfail++;
         $display("FAIL reset_outputs: got psel=%b pen=%b pwr=%b rv=%b re=%b paddr=%h want all 0",
                  psel, penable, pwrite, rsp_valid, rsp_err, paddr);
      end
      preset = 1'b0;
      tick();
      nvec++;
      if (cmd_ready !== 1'b1) begin
         nfail++;
         $display("FAIL reset_release_ready: got %b want 1", cmd_ready);
      end
   endtask

   task automatic test_write_read;
      do_cmd(1'b1, 32'h7000_0000, 32'd6);
      nvec++;
      if (lat !== 3 || pen_cyc !== 1 || !psel_seen) begin
         nfail++;
         $display("FAIL wr_timing: got lat=%0d pen=%0d psel=%b want 3 1 1", lat, pen_cyc, psel_seen);
      end
      nvec++;
      if (!addr_ok) begin
         nfail++;
         $display("FAIL wr_addr_stable: got unstable paddr/pwdata want stable");
      end
      nvec++;
      if (r_err !== 1'b0 || r_data !== 32'h0) begin
         nfail++;
         $display("FAIL wr_rsp: got err=%b rdata=%h want 0 0", r_err, r_data);
      end
      rsp_take();
      nvec++;
      if (rsp_valid !== 1'b0 || cmd_ready !== 1'b1) begin
         nfail++;
         $display("FAIL wr_handshake: got rv=%b rdy=%b want 0 1", rsp_valid, cmd_ready);
      end
      do_cmd(1'b0, 32'h7000_0000, 32'h0);
      nvec++;
      if (lat !== 3 || r_data !== 32'd6 || r_err !== 1'b0) begin
         nfail++;
         $display("FAIL rd_back: got lat=%0d rdata=%h err=%b want 3 6 0", lat, r_data, r_err);
      end
      rsp_take();
   endtask

   task automatic test_wait_states;
      n_wait = 3;
      do_cmd(1'b0, 32'h7000_0004, 32'h0);
      nvec++;
      if (lat !== 6 || pen_cyc !== 4) begin
         nfail++;
         $display("FAIL ws_timing: got lat=%0d pen=%0d want 6 4", lat, pen_cyc);
      end
      nvec++;
      if (!addr_ok || r_data !== 32'h0b1407e9 || r_err !== 1'b0) begin
         nfail++;
         $display("FAIL ws_data: got ok=%b rdata=%h err=%b want 1 0b1407e9 0", addr_ok, r_data, r_err);
      end
      rsp_take();
      n_wait = 0;
   endtask

   task automatic test_window;
      logic [31:0] bad [4];
      bad = '{32'h7000_0010, 32'h7000_0002, 32'h6fff_fffc, 32'h7000_000f};
      for (int i = 0; i < 4; i++) begin
         do_cmd(1'b0, bad[i], 32'h0);
         nvec++;
         if (lat !== 1 || r_err !== 1'b1 || r_data !== 32'h0 || psel_seen) begin
            nfail++;
            $display("FAIL win_err[%h]: got lat=%0d err=%b rdata=%h psel=%b want 1 1 0 0",
                     bad[i], lat, r_err, r_data, psel_seen);
         end
         rsp_take();
      end
      do_cmd(1'b0, 32'h7000_000c, 32'h0);
      nvec++;
      if (lat !== 3 || r_err !== 1'b0 || r_data !== 32'h4b455931) begin
         nfail++;
         $display("FAIL win_top: got lat=%0d err=%b rdata=%h want 3 0 4b455931", lat, r_err, r_data);
      end
      rsp_take();
   endtask

   task automatic test_slverr_hold;
      int bad = 0;
      slv_err = 1'b1;
      do_cmd(1'b1, 32'h7000_0008, 32'h6170_6861);
      slv_err = 1'b0;
      nvec++;
      if (lat !== 3 || r_err !== 1'b1 || r_data !== 32'h0) begin
         nfail++;
         $display("FAIL slverr_rsp: got lat=%0d err=%b rdata=%h want 3 1 0", lat, r_err, r_data);
      end
      for (int i = 0; i < 5; i++) begin
         cmd_valid = (i == 2);
         cmd_write = 1'b1;
         cmd_addr  = 32'h7000_0000;
         cmd_wdata = 32'hdead_beef;
         if (rsp_valid !== 1'b1 || rsp_err !== 1'b1 || rsp_rdata !== 32'h0 || cmd_ready !== 1'b0)
            bad++;
         tick();
      end
      cmd_valid = 1'b0;
      nvec++;
      if (bad !== 0) begin
         nfail++;
         $display("FAIL slverr_hold: got %0d unstable cycles want 0", bad);
      end
      rsp_take();
      bad = 0;
      for (int i = 0; i < 4; i++) begin
         if (psel || rsp_valid) bad++;
         tick();
      end
      nvec++;
      if (bad !== 0) begin
         nfail++;
         $display("FAIL ignored_cmd: got %0d busy cycles want 0", bad);
      end
      do_cmd(1'b0, 32'h7000_0000, 32'h0);
      nvec++;
      if (r_data !== 32'd6) begin
         nfail++;
         $display("FAIL ignored_cmd_mem: got %h want 6", r_data);
      end
      rsp_take();
   endtask

   task automatic test_back_to_back;
      bit gap_ok = 1'b1;
      do_cmd(1'b0, 32'h7000_0004, 32'h0);
      if (psel) gap_ok = 1'b0;
      rsp_take();
      if (psel || !cmd_ready) gap_ok = 1'b0;
      do_cmd(1'b0, 32'h7000_000c, 32'h0);
      nvec++;
      if (!gap_ok || lat !== 3 || r_data !== 32'h4b455931) begin
         nfail++;
         $display("FAIL b2b: got gap_ok=%b lat=%0d rdata=%h want 1 3 4b455931", gap_ok, lat, r_data);
      end
      rsp_take();
   endtask

   task automatic test_reset_mid;
      int bad = 0;
      int w = 0;
      n_wait = 5;
      while (!cmd_ready && w < 20) begin
         tick();
         w++;
      end
      cmd_valid = 1'b1;
      cmd_write = 1'b0;
      cmd_addr  = 32'h7000_0004;
      tick();
      cmd_valid = 1'b0;
      tick();
      tick();
      nvec++;
      if (psel !== 1'b1 || penable !== 1'b1) begin
         nfail++;
         $display("FAIL mid_access: got psel=%b pen=%b want 1 1", psel, penable);
      end
      preset = 1'b1;
      tick();
      preset = 1'b0;
      nvec++;
      if (psel !== 1'b0 || penable !== 1'b0 || rsp_valid !== 1'b0) begin
         nfail++;
         $display("FAIL mid_reset: got psel=%b pen=%b rv=%b want 0 0 0", psel, penable, rsp_valid);
      end
      for (int i = 0; i < 20; i++) begin
         if (psel || rsp_valid) bad++;
         tick();
      end
      nvec++;
      if (bad !== 0 || cmd_ready !== 1'b1) begin
         nfail++;
         $display("FAIL mid_no_rsp: got busy=%0d rdy=%b want 0 1", bad, cmd_ready);
      end
      n_wait = 0;
   endtask

   task automatic test_timeout;
      hang = 1'b1;
`ifdef APB_TIMEOUT_EN
      do_cmd(1'b0, 32'h7000_0004, 32'h0);
      nvec++;
      if (lat !== 18 || pen_cyc !== 16 || r_err !== 1'b1 || r_data !== 32'h0 || psel !== 1'b0) begin
         nfail++;
         $display("FAIL timeout: got lat=%0d pen=%0d err=%b rdata=%h psel=%b want 18 16 1 0 0",
                  lat, pen_cyc, r_err, r_data, psel);
      end
      rsp_take();
`else
      cmd_valid = 1'b1;
      cmd_write = 1'b0;
      cmd_addr  = 32'h7000_0004;
      tick();
      cmd_valid = 1'b0;
      repeat (100) tick();
      nvec++;
      if (psel !== 1'b1 || penable !== 1'b1 || rsp_valid !== 1'b0) begin
         nfail++;
         $display("FAIL no_timeout: got psel=%b pen=%b rv=%b want 1 1 0", psel, penable, rsp_valid);
      end
      preset = 1'b1;
      tick();
      preset = 1'b0;
      tick();
`endif
      hang = 1'b0;
   endtask

   initial begin
      test_reset();
      test_write_read();
      test_wait_states();
      test_window();
      test_slverr_hold();
      test_back_to_back();
      test_reset_mid();
      test_timeout();
      $display("== %0d vectors applied, %0d miscompares ==", nvec, nfail);
      $finish;
   end

endmodule

// File: doc/apb_cmd_master.md
Name: apb_cmd_master

Overview:
- Upstream APB requester for the register slave mapped at 0x7000_0000: data, date, and two 4-char ID words at +0x0/+0x4/+0x8/+0xC.
- Turns a valid/ready command stream (single read or write) into a compliant APB SETUP/ACCESS transfer, and returns the result on a valid/ready response channel.
- One transaction outstanding at a time; address-window and alignment checks are done before the bus is touched.

Parameters:
- BASE_ADDR, 32'h7000_0000, first byte address of the slave window
- WINDOW_BYTES, 16, window size in bytes; power of two, at least 4
- TIMEOUT_CYC, 16, ACCESS cycles with pready low before abort; used only with APB_TIMEOUT_EN

Ports:
- pclk  in  1  clock, all logic on rising edge
- preset  in  1  synchronous active-high reset
- cmd_valid  in  1  command present
- cmd_ready  out  1  command accepted when both high at an edge
- cmd_write  in  1  1=write, 0=read
- cmd_addr  in  32  byte address
- cmd_wdata  in  32  write data
- rsp_valid  out  1  response present
- rsp_ready  in  1  response consumed when both high
- rsp_rdata  out  32  read data; 0 for writes and errors
- rsp_err  out  1  slave error, window/alignment error, or timeout
- psel  out  1  APB select
- penable  out  1  APB enable
- pwrite  out  1  APB direction
- paddr  out  32  APB address
- pwdata  out  32  APB write data
- prdata  in  32  APB read data
- pready  in  1  APB ready
- pslverr  in  1  APB error, valid only with pready

Behaviour:
- All outputs registered.
- Reset: state IDLE; psel, penable, pwrite, paddr, pwdata, rsp_valid, rsp_rdata and rsp_err all 0; cmd_ready 0 during reset, 1 on the first edge after it.
- FSM states: IDLE, SETUP, ACCESS, RESP.
- IDLE:
  - cmd_ready=1; APB outputs all 0.
  - On cmd_valid&cmd_ready, latch write, addr and wdata.
  - If addr is outside [BASE_ADDR, BASE_ADDR+WINDOW_BYTES-1] or addr[1:0]!=0: go to RESP with rsp_err=1, rsp_rdata=0. No psel is ever raised.
  - Otherwise go to SETUP.
- SETUP (exactly 1 cycle): psel=1, penable=0, paddr/pwrite/pwdata driven from the latched values; go to ACCESS.
- ACCESS:
  - psel=1, penable=1; paddr, pwrite and pwdata held stable.
  - On an edge with pready=1: rsp_err=pslverr; rsp_rdata=prdata for reads, 0 for writes; go to RESP.
  - On that same edge, psel, penable, pwrite, paddr and pwdata all return to 0.
- RESP: rsp_valid=1 with rdata/err held stable until rsp_ready=1; then go to IDLE and clear rsp_valid.
- cmd_ready=0 in SETUP, ACCESS and RESP; commands presented then are not accepted.
- Latency (zero wait states, command accepted at edge N): psel high at N+1, penable high at N+2, rsp_valid high at N+3. Each slave wait state adds one cycle.
- Window-error latency: rsp_valid high at N+1.
- pready and pslverr are ignored outside ACCESS; prdata is ignored on writes.
- Back-to-back: the next command can be accepted one cycle after the response handshake, because IDLE shows cmd_ready first. psel is therefore low for at least 2 cycles between transfers.
- Reset mid-transfer: on the reset edge everything returns to reset values; the pending response is discarded; no response is ever issued for the aborted command.

Optional Feature:
- Macro: APB_TIMEOUT_EN.
- Defined:
  - A counter clears on entry to ACCESS and increments each ACCESS cycle with pready=0.
  - When it reaches TIMEOUT_CYC without pready: deassert psel/penable, go to RESP with rsp_err=1 and rsp_rdata=0.
  - A pready on the same edge as the terminal count wins; a normal completion is reported.
- Not defined: no counter logic exists; ACCESS waits for pready indefinitely.

Test Plan:
- Write 0x7000_0000 data 6, pready=1 immediately:
  - psel at N+1, penable at N+2, paddr/pwdata stable, rsp_valid at N+3, rsp_err=0, rsp_rdata=0.
  - Read-back of 0x7000_0000 returns rsp_rdata=6.
- Read 0x7000_0004 with slave holding 32'h0b1407e9 and 3 wait states: penable high 4 cycles, paddr constant, rsp_rdata=32'h0b1407e9 at N+6.
- Commands to 0x7000_0010 (outside window) and to 0x7000_0002 (misaligned): psel never rises, rsp_valid at N+1, rsp_err=1, rsp_rdata=0.
- Write 0x7000_0008 data "apha" with pslverr=1 on the pready cycle: rsp_err=1. Then hold rsp_ready=0 for 5 cycles: response stable, cmd_ready=0, and a cmd_valid pulse in that window is ignored.
- Reset pulse in the 2nd ACCESS cycle of a read: next edge psel=penable=rsp_valid=0, and no response appears afterwards.
- With APB_TIMEOUT_EN and TIMEOUT_CYC=16, pready tied 0: rsp_err=1 after 16 ACCESS cycles and psel drops. Without the macro, psel is still high after 100 cycles.
